// File: rtl/uart_tx_fifo_drain_if.sv
// Pop-side view of the byte FIFO: first-word-fall-through read data, empty flag
// and the pop strobe returned by the consumer.
interface uart_tx_fifo_drain_if;
  logic [7:0] dat;
  logic       empty;
  logic       pop;

  modport master (output dat, output empty, input pop);
  modport slave  (input dat, input empty, output pop);
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// 8N1/8N2 UART transmitter that drains a FWFT byte FIFO, popping one byte per
// frame and shifting it out LSB first on a registered, idle-high TX line.
module uart_tx_fifo_drain #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  uart_tx_fifo_drain_if.slave  fifo,
  output logic                 o_tx,
  output logic                 o_busy
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  state_t            next_state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic              stop_cnt;
  logic              baud_done;
  logic              pop;

  assign baud_done = (baud_cnt == BAUD_LAST);
  assign fifo.pop  = pop;
  assign o_busy    = (state != IDLE);

  // Pop is gated by reset so a byte is never taken while the block is being cleared
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        pop = ~fifo.empty & ~i_reset;
        if (pop) next_state = START;
      end
      START: if (baud_done) next_state = DATA;
      DATA:  if (baud_done && bit_cnt == 3'd7) next_state = STOP;
      STOP:  if (baud_done && stop_cnt == STOP_LAST) next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= next_state;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_tx     <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      stop_cnt <= 1'b0;
    end else if (state == IDLE) begin
      o_tx     <= 1'b1;
      baud_cnt <= '0;
      stop_cnt <= 1'b0;
      if (pop) begin
        shift <= fifo.dat;
        o_tx  <= 1'b0;
      end
    end else begin
      baud_cnt <= baud_done ? '0 : baud_cnt + BAUD_W'(1);
      // The next data bit is taken from shift[1] because the shift happens on the same edge
      case (state)
        START: begin
          if (baud_done) begin
            o_tx    <= shift[0];
            bit_cnt <= 3'd0;
          end
        end
        DATA: begin
          if (baud_done) begin
            if (bit_cnt == 3'd7) begin
              o_tx <= 1'b1;
            end else begin
              o_tx    <= shift[1];
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        STOP: begin
          if (baud_done) stop_cnt <= stop_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Three transmitter lanes (N=4/S=1, N=4/S=2, N=2/S=1), each fed by a 4-deep FWFT
// FIFO model; a UART decoder monitor checks frames against an expected-byte queue.
module tb_uart_tx_fifo_drain;

  logic       clk = 1'b0;
  logic [2:0] rst_v;
  logic [2:0] tx_v;
  logic [2:0] busy_v;
  logic [2:0] pop_v;
  logic [2:0] push_en;
  logic [7:0] push_dat [3];
  logic [2:0] fcnt [3];
  logic       fifo_clr;
  logic [7:0] junk;

  int checks   = 0;
  int failures = 0;
  int cyc_now  = 0;

  int   pop_cnt [3];
  int   last_pop [3];
  int   pop_gap [3];
  int   busy_run [3];
  int   last_busy_len [3];
  logic in_frame [3];
  int   dcyc [3];
  logic start_bit [3];
  logic [7:0] dsh [3];

  // {lane[1:0], byte}
  logic [9:0] exp_q [$];

  always #5 clk = ~clk;

  assign junk = cyc_now[7:0];

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int N = (g == 2) ? 2 : 4;
    localparam int S = (g == 1) ? 2 : 1;

    uart_tx_fifo_drain_if bus();

    logic [7:0] mem [4];
    logic [1:0] rp;
    logic [1:0] wp;
    logic [2:0] cnt;
    wire        do_push = push_en[g] && (cnt != 3'd4 || bus.pop);
    wire        do_pop  = bus.pop && (cnt != 3'd0);

    // Empty FIFO presents changing garbage so the DUT must ignore read data then
    assign bus.dat   = (cnt == 3'd0) ? junk : mem[rp];
    assign bus.empty = (cnt == 3'd0);
    assign pop_v[g]  = bus.pop;
    assign fcnt[g]   = cnt;

    always @(posedge clk) begin
      if (fifo_clr) begin
        rp  <= 2'd0;
        wp  <= 2'd0;
        cnt <= 3'd0;
      end else begin
        if (do_push) begin
          mem[wp] <= push_dat[g];
          wp      <= wp + 2'd1;
        end
        if (do_pop) rp <= rp + 2'd1;
        cnt <= cnt + 3'(do_push) - 3'(do_pop);
      end
    end

    uart_tx_fifo_drain #(.CLKS_PER_BIT(N), .STOP_BITS(S)) dut (
      .i_clk   (clk),
      .i_reset (rst_v[g]),
      .fifo    (bus.slave),
      .o_tx    (tx_v[g]),
      .o_busy  (busy_v[g])
    );
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int g, input logic [7:0] d, input bit expect_frame);
    push_en[g]  = 1'b1;
    push_dat[g] = d;
    if (expect_frame) exp_q.push_back({2'(g), d});
    @(posedge clk);
    #1;
    push_en[g] = 1'b0;
  endtask

  task automatic wait_drained(input int g, input int max_cycles);
    int i;
    i = 0;
    while (i < max_cycles && (fcnt[g] != 3'd0 || busy_v[g] || pop_v[g])) begin
      @(negedge clk);
      i++;
    end
    if (i == max_cycles) checkOutput($sformatf("drain timeout lane%0d", g), 64'd1, 64'd0);
  endtask

  // Monitor: pop/busy statistics and mid-bit UART decoding, compared against exp_q
  initial begin
    int n;
    logic [9:0] e;
    for (int g = 0; g < 3; g++) begin
      pop_cnt[g] = 0; last_pop[g] = 0; pop_gap[g] = 0;
      busy_run[g] = 0; last_busy_len[g] = 0;
      in_frame[g] = 1'b0; dcyc[g] = 0; start_bit[g] = 1'b0; dsh[g] = 8'h00;
    end
    forever begin
      @(negedge clk);
      cyc_now++;
      for (int g = 0; g < 3; g++) begin
        n = (g == 2) ? 2 : 4;
        if (pop_v[g] === 1'b1) begin
          pop_gap[g]  = cyc_now - last_pop[g];
          last_pop[g] = cyc_now;
          pop_cnt[g]++;
        end
        if (busy_v[g] === 1'b1) begin
          busy_run[g]++;
        end else if (busy_run[g] != 0) begin
          last_busy_len[g] = busy_run[g];
          busy_run[g]      = 0;
        end
        if (rst_v[g]) begin
          in_frame[g] = 1'b0;
        end else if (!in_frame[g]) begin
          if (tx_v[g] === 1'b0) begin
            in_frame[g] = 1'b1;
            dcyc[g]     = 0;
          end
        end else begin
          dcyc[g]++;
          if (dcyc[g] == n / 2) start_bit[g] = tx_v[g];
          for (int k = 0; k < 8; k++)
            if (dcyc[g] == (k + 1) * n + n / 2) dsh[g][k] = tx_v[g];
          if (dcyc[g] == 9 * n + n / 2) begin
            in_frame[g] = 1'b0;
            if (exp_q.size() == 0) begin
              checkOutput($sformatf("unexpected frame lane%0d", g), {54'd0, 2'(g), dsh[g]}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              checkOutput($sformatf("frame lane%0d", g),
                          {52'd0, 2'(g), start_bit[g], tx_v[g], dsh[g]},
                          {52'd0, e[9:8], 1'b0, 1'b1, e[7:0]});
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int pc;
    int bad;
    logic [40:0] act_tx, exp_tx, act_busy, exp_busy;
    logic [7:0]  b;

    rst_v    = 3'b111;
    push_en  = 3'b000;
    fifo_clr = 1'b1;
    for (int g = 0; g < 3; g++) push_dat[g] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    fifo_clr = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++)
      checkOutput($sformatf("reset state lane%0d", g), {61'd0, tx_v[g], busy_v[g], pop_v[g]}, 64'd4);
    @(posedge clk);
    #1;
    rst_v = 3'b100;

    // Single byte 0xA5: exact cycle-by-cycle waveform
    pc = pop_cnt[0];
    applyStimulus(0, 8'hA5, 1'b1);
    @(negedge clk);
    checkOutput("pop A5", {63'd0, pop_v[0]}, 64'd1);
    b = 8'hA5;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      act_tx[c]   = tx_v[0];
      act_busy[c] = busy_v[0];
      exp_tx[c]   = (c < 4) ? 1'b0 : (c < 36) ? b[(c - 4) / 4] : 1'b1;
      exp_busy[c] = (c < 40);
    end
    checkOutput("waveform tx A5", {23'd0, act_tx}, {23'd0, exp_tx});
    checkOutput("waveform busy A5", {23'd0, act_busy}, {23'd0, exp_busy});
    wait_drained(0, 100);
    @(posedge clk);
    #1;
    checkOutput("pop count A5", 64'(pop_cnt[0] - pc), 64'd1);

    // Back-to-back 0x00, 0xFF
    pc = pop_cnt[0];
    applyStimulus(0, 8'h00, 1'b1);
    applyStimulus(0, 8'hFF, 1'b1);
    wait_drained(0, 200);
    @(posedge clk);
    #1;
    checkOutput("pop count 00/FF", 64'(pop_cnt[0] - pc), 64'd2);
    checkOutput("pop gap S1", 64'(pop_gap[0]), 64'd41);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || pop_v[0] !== 1'b0) bad++;
    end
    checkOutput("idle after drain", 64'(bad), 64'd0);

    // Two stop bits on lane 1
    applyStimulus(1, 8'h3C, 1'b1);
    applyStimulus(1, 8'h55, 1'b1);
    wait_drained(1, 200);
    @(posedge clk);
    #1;
    checkOutput("busy len S2", 64'(last_busy_len[1]), 64'd44);
    checkOutput("pop gap S2", 64'(pop_gap[1]), 64'd45);

    // Empty FIFO with toggling read data
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (pop_v[0] !== 1'b0 || tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad++;
    end
    checkOutput("empty idle 100", 64'(bad), 64'd0);

    // Reset during data bit 3 of 0x81, 0x42 queued under reset
    pc = pop_cnt[0];
    applyStimulus(0, 8'h81, 1'b0);
    @(posedge clk);
    repeat (17) @(posedge clk);
    #1;
    rst_v[0]    = 1'b1;
    push_en[0]  = 1'b1;
    push_dat[0] = 8'h42;
    exp_q.push_back({2'd0, 8'h42});
    @(posedge clk);
    #1;
    push_en[0] = 1'b0;
    @(negedge clk);
    checkOutput("reset abort state", {61'd0, tx_v[0], busy_v[0], pop_v[0]}, 64'd4);
    checkOutput("fifo untouched in reset", {61'd0, fcnt[0]}, 64'd1);
    @(posedge clk);
    #1;
    rst_v[0] = 1'b0;
    wait_drained(0, 100);
    @(posedge clk);
    #1;
    checkOutput("pop count reset", 64'(pop_cnt[0] - pc), 64'd2);

    // Full 4-deep FIFO drained at N=2
    pc = pop_cnt[2];
    applyStimulus(2, 8'h11, 1'b1);
    applyStimulus(2, 8'h22, 1'b1);
    applyStimulus(2, 8'h33, 1'b1);
    applyStimulus(2, 8'h44, 1'b1);
    @(negedge clk);
    checkOutput("fifo full in reset", {60'd0, fcnt[2], pop_v[2]}, {60'd0, 3'd4, 1'b0});
    @(posedge clk);
    #1;
    rst_v[2] = 1'b0;
    wait_drained(2, 200);
    @(posedge clk);
    #1;
    checkOutput("pop count full fifo", 64'(pop_cnt[2] - pc), 64'd4);
    checkOutput("fifo empty at end", {61'd0, fcnt[2]}, 64'd0);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("scoreboard leftover", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
